// File: rtl/regfile_seq_pkg.sv
// Shared types and constants for the register-file write sequencer.
package regfile_seq_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    NEXT  = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam logic [1:0] SEL_RADDR1 = 2'd0;
  localparam logic [1:0] SEL_RADDR2 = 2'd1;
  localparam logic [1:0] SEL_WADDR  = 2'd2;
  localparam logic [1:0] SEL_WDATA  = 2'd3;

endpackage

// File: rtl/regfile_write_seq_sync_rise.sv
// Two-flop synchroniser followed by a rising-edge detector for a raw switch input.
module sync_rise (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= din;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  // Combinational so the pulse is visible in the cycle right after the second flop captures.
  assign pulse = sync & ~sync_d;

endmodule

// File: rtl/regfile_write_seq.sv
// Touchscreen command sequencer: captures regfile fields and runs byte-masked write bursts.
module regfile_write_seq
  import regfile_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              input_valid,
  input  logic [REG_DW-1:0] input_value,
  input  logic [1:0]        input_sel,
  input  logic [3:0]        byte_mask,
  input  logic [4:0]        fill_len,
  input  logic              inc_data,
  input  logic              start,
  output logic [REG_AW-1:0] raddr1,
  output logic [REG_AW-1:0] raddr2,
  output logic [REG_AW-1:0] waddr,
  output logic [REG_DW-1:0] wdata,
  output logic [3:0]        wen,
  output logic              busy,
  output logic              done,
  output logic              input_drop,
  output logic              start_err,
  output seq_state_t        state
);

  seq_state_t  state_next;
  logic        start_pulse;
  logic [4:0]  remain;
  logic        inc_lat;
  logic        start_ok;

  sync_rise u_start_sync (
    .clk   (clk),
    .reset (reset),
    .din   (start),
    .pulse (start_pulse)
  );

  assign start_ok = (state == IDLE) && start_pulse && (byte_mask != 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = WRITE;
      WRITE:   state_next = (remain == 5'd0) ? DONE : NEXT;
      NEXT:    state_next = WRITE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // wen comes straight from the state register so reset removes it without waiting for a clock.
  assign wen  = (state == WRITE) ? byte_mask : 4'd0;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raddr1     <= '0;
      raddr2     <= '0;
      waddr      <= '0;
      wdata      <= '0;
      remain     <= '0;
      inc_lat    <= 1'b0;
      done       <= 1'b0;
      input_drop <= 1'b0;
      start_err  <= 1'b0;
    end else begin
      done       <= (state == WRITE) && (remain == 5'd0);
      input_drop <= 1'b0;
      start_err  <= (state == IDLE) && start_pulse && (byte_mask == 4'd0);

      if (input_valid) begin
        case (input_sel)
          SEL_RADDR1: raddr1 <= input_value[REG_AW-1:0];
          SEL_RADDR2: raddr2 <= input_value[REG_AW-1:0];
          SEL_WADDR: begin
            if (state == IDLE) waddr <= input_value[REG_AW-1:0];
            else               input_drop <= 1'b1;
          end
          default: begin
            if (state == IDLE) wdata <= input_value;
            else               input_drop <= 1'b1;
          end
        endcase
      end

      if (start_ok) begin
        remain  <= fill_len;
        inc_lat <= inc_data;
      end

      // Write-field captures only happen in IDLE, so NEXT never competes with them.
      if (state == NEXT) begin
        waddr  <= waddr + 5'd1;
        remain <= remain - 5'd1;
        if (inc_lat) wdata <= wdata + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_seq.sv
// Directed bench for regfile_write_seq with a write scoreboard and status pulse counters.
`timescale 1ns/1ps
module tb_regfile_write_seq;
  import regfile_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        input_valid = 1'b0;
  logic [31:0] input_value = '0;
  logic [1:0]  input_sel = '0;
  logic [3:0]  byte_mask = '0;
  logic [4:0]  fill_len = '0;
  logic        inc_data = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  raddr1, raddr2, waddr;
  logic [31:0] wdata;
  logic [3:0]  wen;
  logic        busy, done, input_drop, start_err;
  seq_state_t  state;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int drop_cnt = 0;
  int err_cnt = 0;
  int busy_cyc = 0;

  // Expected write tuple: {wen, waddr, wdata}
  logic [40:0] exp_q[$];

  regfile_write_seq dut (
    .clk(clk), .reset(reset), .input_valid(input_valid), .input_value(input_value),
    .input_sel(input_sel), .byte_mask(byte_mask), .fill_len(fill_len), .inc_data(inc_data),
    .start(start), .raddr1(raddr1), .raddr2(raddr2), .waddr(waddr), .wdata(wdata),
    .wen(wen), .busy(busy), .done(done), .input_drop(input_drop), .start_err(start_err),
    .state(state)
  );

  always #50 clk = ~clk;

  // Monitor: every write cycle pops one expected tuple; status pulses are counted.
  always @(negedge clk) begin
    if (!reset) begin
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      if (input_drop) drop_cnt++;
      if (start_err) err_cnt++;
      if (wen != 4'd0) begin
        wr_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected act wen=%h addr=%0d data=%h exp none", wen, waddr, wdata);
        end else begin
          logic [40:0] e;
          e = exp_q.pop_front();
          if ({wen, waddr, wdata} !== e) begin
            errors++;
            $display("FAIL write act %h exp %h", {wen, waddr, wdata}, e);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act %h exp %h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [3:0] m, input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({m, a, d});
  endtask

  task automatic enter(input logic [1:0] sel, input logic [31:0] val);
    @(posedge clk); #1;
    input_valid = 1'b1; input_sel = sel; input_value = val;
    @(posedge clk); #1;
    input_valid = 1'b0;
  endtask

  task automatic wait_busy(input string name);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (busy) break;
    end
    check(name, {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (!busy) break;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int b_done, b_busy, b_drop, b_err, b_wr;

    do_reset();
    @(negedge clk);
    check("rst_raddr1", {27'd0, raddr1}, 32'd0);
    check("rst_waddr", {27'd0, waddr}, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_status", {26'd0, wen, busy, done}, 32'd0);

    // Single write
    enter(SEL_WADDR, 32'd5);
    enter(SEL_WDATA, 32'h0000_00AA);
    byte_mask = 4'hF; fill_len = 5'd0; inc_data = 1'b0;
    push_wr(4'hF, 5'd5, 32'hAA);
    b_done = done_cnt; b_busy = busy_cyc;
    start = 1'b1;
    wait_busy("t1_busy_rise");
    wait_idle("t1_busy_fall");
    start = 1'b0;
    repeat (3) @(posedge clk);
    check("t1_done", done_cnt - b_done, 1);
    check("t1_busy_cycles", busy_cyc - b_busy, 2);

    // Wrapping burst with data increment
    enter(SEL_WADDR, 32'd30);
    enter(SEL_WDATA, 32'h10);
    byte_mask = 4'h3; fill_len = 5'd3; inc_data = 1'b1;
    push_wr(4'h3, 5'd30, 32'h10);
    push_wr(4'h3, 5'd31, 32'h11);
    push_wr(4'h3, 5'd0, 32'h12);
    push_wr(4'h3, 5'd1, 32'h13);
    b_done = done_cnt; b_busy = busy_cyc;
    start = 1'b1;
    wait_busy("t2_busy_rise");
    wait_idle("t2_busy_fall");
    start = 1'b0;
    repeat (3) @(posedge clk);
    check("t2_waddr_after", {27'd0, waddr}, 32'd1);
    check("t2_wdata_after", wdata, 32'h13);
    check("t2_done", done_cnt - b_done, 1);
    check("t2_busy_cycles", busy_cyc - b_busy, 8);

    // Entries during a burst: write fields dropped, read address accepted
    byte_mask = 4'hF; fill_len = 5'd5; inc_data = 1'b0;
    for (int i = 0; i < 6; i++) push_wr(4'hF, 5'(1 + i), 32'h13);
    b_drop = drop_cnt;
    start = 1'b1;
    wait_busy("t3_busy_rise");
    enter(SEL_WDATA, 32'hFFFF);
    check("t3_wdata_kept", wdata, 32'h13);
    enter(SEL_RADDR1, 32'd7);
    check("t3_raddr1", {27'd0, raddr1}, 32'd7);
    wait_idle("t3_busy_fall");
    start = 1'b0;
    repeat (3) @(posedge clk);
    check("t3_drop", drop_cnt - b_drop, 1);
    check("t3_waddr_after", {27'd0, waddr}, 32'd6);

    // Zero mask start is rejected
    byte_mask = 4'h0;
    b_err = err_cnt; b_busy = busy_cyc; b_wr = wr_cnt;
    start = 1'b1;
    repeat (6) @(posedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    check("t4_start_err", err_cnt - b_err, 1);
    check("t4_busy_cycles", busy_cyc - b_busy, 0);
    check("t4_no_write", wr_cnt - b_wr, 0);

    // Reset during the third write of a six-write burst
    enter(SEL_RADDR2, 32'd9);
    byte_mask = 4'hF; fill_len = 5'd5; inc_data = 1'b0;
    push_wr(4'hF, 5'd6, 32'h13);
    push_wr(4'hF, 5'd7, 32'h13);
    push_wr(4'hF, 5'd8, 32'h13);
    b_wr = wr_cnt; b_done = done_cnt;
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (wr_cnt - b_wr == 3) break;
    end
    check("t5_reached_w3", wr_cnt - b_wr, 3);
    check("t5_pre_raddr2", {27'd0, raddr2}, 32'd9);
    reset = 1'b1;
    #1;
    check("t5_wen_busy", {27'd0, wen, busy}, 32'd0);
    check("t5_addrs", {17'd0, raddr1, raddr2, waddr}, 32'd0);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    check("t5_no_done", done_cnt - b_done, 0);

    // Start toggled during a burst runs exactly one burst
    enter(SEL_WADDR, 32'd10);
    enter(SEL_WDATA, 32'h55);
    byte_mask = 4'hF; fill_len = 5'd2; inc_data = 1'b0;
    for (int i = 0; i < 3; i++) push_wr(4'hF, 5'(10 + i), 32'h55);
    b_done = done_cnt; b_busy = busy_cyc;
    start = 1'b1;
    wait_busy("t6_busy_rise");
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    wait_idle("t6_busy_fall");
    repeat (10) @(posedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    check("t6_done", done_cnt - b_done, 1);
    check("t6_busy_cycles", busy_cyc - b_busy, 6);

    @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout act running exp finished");
    $fatal(1, "timeout");
  end

endmodule
